anabellek_denetleyici: RTL and testbench
========================================

ANABELLEK_DENETLEYICI -- requirements
Module: anabellek_denetleyici

Interface
REQ-001 SHALL have parameter ZAMAN_ASIMI, default 255, meaning max consecutive cycles bellek_istek_o may stay high without bellek_gecerli_i before abort (legal range 1..65535).
REQ-002 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have anabellek_istek_i  input  1  cache request strobe.
REQ-005 SHALL have anabellek_oku_i  input  1  1 = 128-bit line read, 0 = 128-bit line write.
REQ-006 SHALL have anabellek_adres_i  input  32  line address from cache.
REQ-007 SHALL have anabellek_yaz_obek_i  input  128  write line data; word k in bits [32k+31:32k].
REQ-008 SHALL have anabellek_musait_o  output  1  controller idle, request will be accepted.
REQ-009 SHALL have anabellek_hazir_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have anabellek_obek_o  output  128  assembled read line; word k in bits [32k+31:32k].
REQ-011 SHALL have anabellek_hata_o  output  1  timeout flag, valid with anabellek_hazir_o.
REQ-012 SHALL have bellek_istek_o  output  1  word request to backing memory.
REQ-013 SHALL have bellek_yaz_o  output  1  1 = word write, 0 = word read.
REQ-014 SHALL have bellek_adres_o  output  32  word byte address.
REQ-015 SHALL have bellek_veri_o  output  32  word write data.
REQ-016 SHALL have bellek_gecerli_i  input  1  memory accept/ack; for reads, bellek_veri_i valid same cycle.
REQ-017 SHALL have bellek_veri_i  input  32  word read data.

Function
REQ-018 SHALL implement states BOSTA, OKU, YAZ, TAMAM.
REQ-019 SHALL drive anabellek_musait_o = 1 only in BOSTA.
REQ-020 In BOSTA with anabellek_istek_i = 1, SHALL latch base address {anabellek_adres_i[31:4], 4'b0000}, clear word counter k to 0, clear timeout counter, and go to OKU (oku_i = 1, obek register cleared to 0) or YAZ (oku_i = 0, anabellek_yaz_obek_i latched).
REQ-021 SHALL ignore anabellek_istek_i, anabellek_oku_i, anabellek_adres_i, anabellek_yaz_obek_i outside BOSTA; a dropped anabellek_istek_i SHALL NOT abort an accepted transaction.
REQ-022 In OKU/YAZ SHALL drive bellek_istek_o = 1, bellek_adres_o = base + 4*k, bellek_yaz_o = (state == YAZ), bellek_veri_o = latched word k (0 in OKU).
REQ-023 On bellek_gecerli_i = 1 in OKU SHALL store bellek_veri_i into obek bits [32k+31:32k]; in YAZ the cycle counts as write ack.
REQ-024 On each bellek_gecerli_i = 1 SHALL increment k (2-bit) and clear timeout counter; when k == 3 SHALL go to TAMAM instead.
REQ-025 Next word request SHALL issue the cycle after the previous ack (bellek_istek_o stays high, address advances).
REQ-026 Best-case latency: istek_i accepted cycle 0, words acked cycles 1-4, anabellek_hazir_o high cycle 5.
REQ-027 In TAMAM SHALL assert anabellek_hazir_o for exactly one cycle, then go to BOSTA.
REQ-028 anabellek_obek_o SHALL reflect the obek register continuously and hold its value after TAMAM until the next read acceptance; writes SHALL NOT modify it.
REQ-029 Timeout counter SHALL increment each OKU/YAZ cycle without bellek_gecerli_i; on reaching ZAMAN_ASIMI SHALL go to TAMAM with anabellek_hata_o = 1; unreceived words remain 0.
REQ-030 anabellek_hata_o SHALL be 0 whenever anabellek_hazir_o is 0.
REQ-031 bellek_gecerli_i in BOSTA or TAMAM SHALL be ignored.
REQ-032 bellek_istek_o, bellek_yaz_o SHALL be 0 and bellek_adres_o, bellek_veri_o SHALL be 0 in BOSTA and TAMAM.

Reset
REQ-033 With rst_i = 0 at a clock edge SHALL enter BOSTA, clear k, timeout counter, latched address/data and obek register to 0, at any state including mid-transaction.
REQ-034 Post-reset outputs: anabellek_musait_o = 1, anabellek_hazir_o = 0, anabellek_hata_o = 0, anabellek_obek_o = 0, bellek_istek_o = 0, bellek_yaz_o = 0, bellek_adres_o = 0, bellek_veri_o = 0.

Verification
REQ-035 Read 0x0000_1234, gecerli every cycle, data 0xA0,0xA1,0xA2,0xA3 -> addresses 0x1230,0x1234,0x1238,0x123C; hazir at cycle 5; obek = 0x000000A3_000000A2_000000A1_000000A0; hata 0.
REQ-036 Write 0x0000_2000, yaz_obek = 0x44444444_33333333_22222222_11111111, gecerli with 2-cycle gaps -> bellek_yaz_o = 1, data 0x11111111..0x44444444 in order, hazir one cycle after 4th ack, obek unchanged.
REQ-037 Read accepted, istek_i dropped next cycle -> transaction still completes with hazir pulse; musait 0 until cycle after hazir.
REQ-038 ZAMAN_ASIMI = 4, read, gecerli once then never -> hazir and hata together after 4 idle cycles; obek word 0 = data, words 1-3 = 0.
REQ-039 rst_i = 0 after second word ack -> next cycle all outputs at REQ-034 values; new read completes normally.

Source files
------------

// File: rtl/anabellek_denetleyici.sv
// rtl/anabellek_denetleyici.sv - cache line to 4-word backing memory controller
// Splits each 128-bit line read/write into four 32-bit word transactions with a per-word timeout.
module anabellek_denetleyici #(
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         anabellek_istek_i,
  input  logic         anabellek_oku_i,
  input  logic [31:0]  anabellek_adres_i,
  input  logic [127:0] anabellek_yaz_obek_i,
  output logic         anabellek_musait_o,
  output logic         anabellek_hazir_o,
  output logic [127:0] anabellek_obek_o,
  output logic         anabellek_hata_o,
  output logic         bellek_istek_o,
  output logic         bellek_yaz_o,
  output logic [31:0]  bellek_adres_o,
  output logic [31:0]  bellek_veri_o,
  input  logic         bellek_gecerli_i,
  input  logic [31:0]  bellek_veri_i
);

  typedef enum logic [1:0] {BOSTA, OKU, YAZ, TAMAM} durum_t;

  // Last idle cycle allowed; reaching it means ZAMAN_ASIMI consecutive cycles without an ack.
  localparam logic [15:0] SINIR = 16'(ZAMAN_ASIMI - 1);

  durum_t         durum_q, durum_d;
  logic [1:0]     k_q, k_d;
  logic [15:0]    zaman_q, zaman_d;
  logic [31:0]    taban_q, taban_d;
  logic [127:0]   yaz_q, yaz_d;
  logic [127:0]   obek_q, obek_d;
  logic           hata_q, hata_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
      k_q     <= 2'd0;
      zaman_q <= 16'd0;
      taban_q <= 32'd0;
      yaz_q   <= 128'd0;
      obek_q  <= 128'd0;
      hata_q  <= 1'b0;
    end else begin
      durum_q <= durum_d;
      k_q     <= k_d;
      zaman_q <= zaman_d;
      taban_q <= taban_d;
      yaz_q   <= yaz_d;
      obek_q  <= obek_d;
      hata_q  <= hata_d;
    end
  end

  always_comb begin
    durum_d = durum_q;
    k_d     = k_q;
    zaman_d = zaman_q;
    taban_d = taban_q;
    yaz_d   = yaz_q;
    obek_d  = obek_q;
    hata_d  = hata_q;
    case (durum_q)
      BOSTA: begin
        if (anabellek_istek_i) begin
          taban_d = {anabellek_adres_i[31:4], 4'b0000};
          k_d     = 2'd0;
          zaman_d = 16'd0;
          hata_d  = 1'b0;
          if (anabellek_oku_i) begin
            durum_d = OKU;
            obek_d  = 128'd0;
          end else begin
            durum_d = YAZ;
            yaz_d   = anabellek_yaz_obek_i;
          end
        end
      end
      OKU, YAZ: begin
        if (bellek_gecerli_i) begin
          if (durum_q == OKU) obek_d[{k_q, 5'b00000} +: 32] = bellek_veri_i;
          zaman_d = 16'd0;
          k_d     = k_q + 2'd1;
          if (k_q == 2'd3) durum_d = TAMAM;
        end else if (zaman_q == SINIR) begin
          durum_d = TAMAM;
          hata_d  = 1'b1;
        end else begin
          zaman_d = zaman_q + 16'd1;
        end
      end
      TAMAM: durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    anabellek_musait_o = 1'b0;
    anabellek_hazir_o  = 1'b0;
    anabellek_hata_o   = 1'b0;
    bellek_istek_o     = 1'b0;
    bellek_yaz_o       = 1'b0;
    bellek_adres_o     = 32'd0;
    bellek_veri_o      = 32'd0;
    case (durum_q)
      BOSTA: anabellek_musait_o = 1'b1;
      OKU, YAZ: begin
        bellek_istek_o = 1'b1;
        bellek_yaz_o   = (durum_q == YAZ);
        bellek_adres_o = taban_q + {28'd0, k_q, 2'b00};
        if (durum_q == YAZ) bellek_veri_o = yaz_q[{k_q, 5'b00000} +: 32];
      end
      TAMAM: begin
        anabellek_hazir_o = 1'b1;
        anabellek_hata_o  = hata_q;
      end
      default: ;
    endcase
  end

  assign anabellek_obek_o = obek_q;

endmodule

// File: tb/tb_anabellek_denetleyici.sv
// tb/tb_anabellek_denetleyici.sv - directed self-checking bench for anabellek_denetleyici
// Runs with ZAMAN_ASIMI = 4 so the timeout path is reachable in a few cycles.
module tb_anabellek_denetleyici;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         anabellek_istek_i;
  logic         anabellek_oku_i;
  logic [31:0]  anabellek_adres_i;
  logic [127:0] anabellek_yaz_obek_i;
  logic         anabellek_musait_o;
  logic         anabellek_hazir_o;
  logic [127:0] anabellek_obek_o;
  logic         anabellek_hata_o;
  logic         bellek_istek_o;
  logic         bellek_yaz_o;
  logic [31:0]  bellek_adres_o;
  logic [31:0]  bellek_veri_o;
  logic         bellek_gecerli_i;
  logic [31:0]  bellek_veri_i;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;

  anabellek_denetleyici #(.ZAMAN_ASIMI(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .anabellek_istek_i(anabellek_istek_i), .anabellek_oku_i(anabellek_oku_i),
    .anabellek_adres_i(anabellek_adres_i), .anabellek_yaz_obek_i(anabellek_yaz_obek_i),
    .anabellek_musait_o(anabellek_musait_o), .anabellek_hazir_o(anabellek_hazir_o),
    .anabellek_obek_o(anabellek_obek_o), .anabellek_hata_o(anabellek_hata_o),
    .bellek_istek_o(bellek_istek_o), .bellek_yaz_o(bellek_yaz_o),
    .bellek_adres_o(bellek_adres_o), .bellek_veri_o(bellek_veri_o),
    .bellek_gecerli_i(bellek_gecerli_i), .bellek_veri_i(bellek_veri_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got %0h expected %0h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim;
    @(posedge clk_i);
    #1;
  endtask

  task automatic bosta_kontrol(input string etiket);
    kontrol({etiket, "_musait"}, anabellek_musait_o, 1'b1);
    kontrol({etiket, "_hazir"},  anabellek_hazir_o, 1'b0);
    kontrol({etiket, "_hata"},   anabellek_hata_o, 1'b0);
    kontrol({etiket, "_bistek"}, bellek_istek_o, 1'b0);
    kontrol({etiket, "_byaz"},   bellek_yaz_o, 1'b0);
    kontrol({etiket, "_badres"}, bellek_adres_o, 32'd0);
    kontrol({etiket, "_bveri"},  bellek_veri_o, 32'd0);
  endtask

  // Accepts one line request; istek is dropped right after acceptance to show it cannot abort.
  task automatic kabul(input bit oku, input logic [31:0] adr, input logic [127:0] yobek);
    kontrol("kabul_musait", anabellek_musait_o, 1'b1);
    anabellek_istek_i    = 1'b1;
    anabellek_oku_i      = oku;
    anabellek_adres_i    = adr;
    anabellek_yaz_obek_i = yobek;
    adim();
    anabellek_istek_i    = 1'b0;
    anabellek_oku_i      = ~oku;
    anabellek_adres_i    = 32'hFFFF_FFF0;
    anabellek_yaz_obek_i = '1;
  endtask

  // Serves word k after 'bosluk' idle cycles, checking the word request each cycle.
  task automatic kelime(input string etiket, input bit yaz, input logic [31:0] adr,
                        input logic [31:0] yveri, input logic [31:0] okuveri, input int bosluk);
    for (int j = 0; j < bosluk; j++) begin
      kontrol({etiket, "_bekle_istek"}, bellek_istek_o, 1'b1);
      kontrol({etiket, "_bekle_adres"}, bellek_adres_o, adr);
      kontrol({etiket, "_bekle_hazir"}, anabellek_hazir_o, 1'b0);
      adim();
    end
    kontrol({etiket, "_istek"},  bellek_istek_o, 1'b1);
    kontrol({etiket, "_yaz"},    bellek_yaz_o, yaz);
    kontrol({etiket, "_adres"},  bellek_adres_o, adr);
    kontrol({etiket, "_veri"},   bellek_veri_o, yveri);
    kontrol({etiket, "_musait"}, anabellek_musait_o, 1'b0);
    bellek_gecerli_i = 1'b1;
    bellek_veri_i    = okuveri;
    adim();
    bellek_gecerli_i = 1'b0;
    bellek_veri_i    = 32'hDEAD_BEEF;
  endtask

  task automatic bitis(input string etiket, input logic hata, input logic [127:0] obek);
    kontrol({etiket, "_hazir"},  anabellek_hazir_o, 1'b1);
    kontrol({etiket, "_hata"},   anabellek_hata_o, hata);
    kontrol({etiket, "_musait"}, anabellek_musait_o, 1'b0);
    kontrol({etiket, "_bistek"}, bellek_istek_o, 1'b0);
    kontrol({etiket, "_obek"},   anabellek_obek_o, obek);
    // Ack arriving in TAMAM must be ignored.
    bellek_gecerli_i = 1'b1;
    bellek_veri_i    = 32'h5555_5555;
    adim();
    bellek_gecerli_i = 1'b0;
    kontrol({etiket, "_sonra_hazir"}, anabellek_hazir_o, 1'b0);
    kontrol({etiket, "_sonra_hata"},  anabellek_hata_o, 1'b0);
    kontrol({etiket, "_sonra_musait"}, anabellek_musait_o, 1'b1);
    kontrol({etiket, "_sonra_obek"},  anabellek_obek_o, obek);
  endtask

  initial begin
    rst_i = 1'b0;
    anabellek_istek_i = 1'b0; anabellek_oku_i = 1'b0;
    anabellek_adres_i = '0;   anabellek_yaz_obek_i = '0;
    bellek_gecerli_i = 1'b1;  bellek_veri_i = 32'h1234_5678;
    adim(); adim();
    bellek_gecerli_i = 1'b0;
    bosta_kontrol("reset");
    kontrol("reset_obek", anabellek_obek_o, 128'd0);
    rst_i = 1'b1;
    adim();
    bosta_kontrol("reset_birak");

    // Back-to-back read: acks in cycles 1-4, hazir in cycle 5.
    kabul(1'b1, 32'h0000_1234, '0);
    kelime("oku0", 1'b0, 32'h0000_1230, 32'd0, 32'h0000_00A0, 0);
    kelime("oku1", 1'b0, 32'h0000_1234, 32'd0, 32'h0000_00A1, 0);
    kelime("oku2", 1'b0, 32'h0000_1238, 32'd0, 32'h0000_00A2, 0);
    kelime("oku3", 1'b0, 32'h0000_123C, 32'd0, 32'h0000_00A3, 0);
    bitis("oku_son", 1'b0, 128'h000000A3_000000A2_000000A1_000000A0);

    // Write with 2-cycle gaps; read line must stay untouched.
    kabul(1'b0, 32'h0000_2000, 128'h44444444_33333333_22222222_11111111);
    kelime("yaz0", 1'b1, 32'h0000_2000, 32'h1111_1111, 32'h0, 2);
    kelime("yaz1", 1'b1, 32'h0000_2004, 32'h2222_2222, 32'h0, 2);
    kelime("yaz2", 1'b1, 32'h0000_2008, 32'h3333_3333, 32'h0, 2);
    kelime("yaz3", 1'b1, 32'h0000_200C, 32'h4444_4444, 32'h0, 2);
    bitis("yaz_son", 1'b0, 128'h000000A3_000000A2_000000A1_000000A0);

    // Gap of ZAMAN_ASIMI-1 idle cycles is the longest that must not time out.
    kabul(1'b1, 32'hABCD_EF0C, '0);
    kelime("sinir0", 1'b0, 32'hABCD_EF00, 32'd0, 32'hCAFE_0000, 3);
    kelime("sinir1", 1'b0, 32'hABCD_EF04, 32'd0, 32'hCAFE_0001, 1);
    kelime("sinir2", 1'b0, 32'hABCD_EF08, 32'd0, 32'hCAFE_0002, 3);
    kelime("sinir3", 1'b0, 32'hABCD_EF0C, 32'd0, 32'hCAFE_0003, 0);
    bitis("sinir_son", 1'b0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);

    // Timeout: one ack, then 4 idle cycles with istek held.
    kabul(1'b1, 32'h0000_3000, '0);
    kelime("zaman0", 1'b0, 32'h0000_3000, 32'd0, 32'h0000_00B0, 0);
    for (int j = 0; j < 4; j++) begin
      kontrol("zaman_bekle_istek", bellek_istek_o, 1'b1);
      kontrol("zaman_bekle_adres", bellek_adres_o, 32'h0000_3004);
      adim();
    end
    bitis("zaman_son", 1'b1, 128'h00000000_00000000_00000000_000000B0);

    // Reset in the middle of a read.
    kabul(1'b1, 32'h0000_4000, '0);
    kelime("rst0", 1'b0, 32'h0000_4000, 32'd0, 32'h0000_00C0, 0);
    kelime("rst1", 1'b0, 32'h0000_4004, 32'd0, 32'h0000_00C1, 0);
    rst_i = 1'b0;
    adim();
    rst_i = 1'b1;
    bosta_kontrol("ara_reset");
    kontrol("ara_reset_obek", anabellek_obek_o, 128'd0);
    kabul(1'b1, 32'h0000_5008, '0);
    kelime("yeni0", 1'b0, 32'h0000_5000, 32'd0, 32'h0000_00D0, 0);
    kelime("yeni1", 1'b0, 32'h0000_5004, 32'd0, 32'h0000_00D1, 1);
    kelime("yeni2", 1'b0, 32'h0000_5008, 32'd0, 32'h0000_00D2, 0);
    kelime("yeni3", 1'b0, 32'h0000_500C, 32'd0, 32'h0000_00D3, 0);
    bitis("yeni_son", 1'b0, 128'h000000D3_000000D2_000000D1_000000D0);

    $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
